// File: rtl/sphere_hit_worker.sv
// Sphere hit worker: for each of JOBS_SUBDIVISION pixels of one row job, tests the pixel
// against every enabled sphere (strict inside-circle test) and stores the lowest-index hit color.
module sphere_hit_worker #(
    parameter int JOBS_SUBDIVISION = 8,
    parameter int N_WORKERS        = 4,
    parameter int N_SPHERES        = 4,
    parameter int COORD_W          = 12,
    parameter int RADIUS_W         = 10,
    parameter int COLOR_W          = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic signed [COORD_W-1:0]            x,
    input  logic signed [COORD_W-1:0]            y,
    input  logic [N_SPHERES*COORD_W-1:0]         sphere_x,
    input  logic [N_SPHERES*COORD_W-1:0]         sphere_y,
    input  logic [N_SPHERES*RADIUS_W-1:0]        sphere_r,
    input  logic [N_SPHERES*COLOR_W-1:0]         sphere_color,
    input  logic [N_SPHERES-1:0]                 sphere_en,
    input  logic [COLOR_W-1:0]                   bg_color,
    output logic                                 busy,
    output logic                                 done,
    output logic [JOBS_SUBDIVISION*COLOR_W-1:0]  buffer
);

    localparam int JW     = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
    localparam int SW     = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
    localparam int LX_W   = COORD_W + 4;
    localparam int DX_W   = LX_W + 1;
    localparam int DY_W   = COORD_W + 1;
    localparam int DIST_W = 2 * DX_W + 1;
    localparam int RSQ_W  = 2 * RADIUS_W;

    typedef enum logic [2:0] {IDLE, DIFF, SQR, CMP, WRITE, DONE} state_t;

    state_t               state_q;
    logic [JW-1:0]        j_q;
    logic [SW-1:0]        s_q;
    logic                 hit_q;
    logic [COLOR_W-1:0]   col_q;
    logic                 busy_q;
    logic                 done_q;
    logic [COLOR_W-1:0]   buffer_q [JOBS_SUBDIVISION];

    // Job snapshot taken at start so later input changes cannot disturb a running job.
    logic [COORD_W-1:0]              x_q;
    logic [COORD_W-1:0]              y_q;
    logic [N_SPHERES*COORD_W-1:0]    sx_q;
    logic [N_SPHERES*COORD_W-1:0]    sy_q;
    logic [N_SPHERES*RADIUS_W-1:0]   sr_q;
    logic [N_SPHERES*COLOR_W-1:0]    scol_q;
    logic [N_SPHERES-1:0]            en_q;
    logic [COLOR_W-1:0]              bg_q;

    logic signed [DX_W-1:0]   dx_q;
    logic signed [DY_W-1:0]   dy_q;
    logic [DIST_W-1:0]        dist_sq_q;
    logic [RSQ_W-1:0]         r_sq_q;

    logic [COORD_W-1:0]       cur_sx;
    logic [COORD_W-1:0]       cur_sy;
    logic [RADIUS_W-1:0]      cur_r;
    logic [COLOR_W-1:0]       cur_col;
    logic [LX_W-1:0]          local_x;
    logic [DX_W-1:0]          dx_d;
    logic [DY_W-1:0]          dy_d;
    logic signed [2*DX_W-1:0] dx_sq;
    logic signed [2*DY_W-1:0] dy_sq;
    logic [DIST_W-1:0]        dist_sq_d;
    logic [RSQ_W-1:0]         r_sq_d;
    logic                     hit_now;

    assign cur_sx  = sx_q[s_q*COORD_W +: COORD_W];
    assign cur_sy  = sy_q[s_q*COORD_W +: COORD_W];
    assign cur_r   = sr_q[s_q*RADIUS_W +: RADIUS_W];
    assign cur_col = scol_q[s_q*COLOR_W +: COLOR_W];

    assign local_x = {{(LX_W-COORD_W){x_q[COORD_W-1]}}, x_q} + LX_W'(j_q) * LX_W'(N_WORKERS);
    assign dx_d    = {local_x[LX_W-1], local_x} - {{(DX_W-COORD_W){cur_sx[COORD_W-1]}}, cur_sx};
    assign dy_d    = {y_q[COORD_W-1], y_q} - {cur_sy[COORD_W-1], cur_sy};

    // Squares of signed differences are non-negative, so zero-extending them into the sum is safe.
    assign dx_sq     = dx_q * dx_q;
    assign dy_sq     = dy_q * dy_q;
    assign dist_sq_d = DIST_W'($unsigned(dx_sq)) + DIST_W'($unsigned(dy_sq));
    assign r_sq_d    = RSQ_W'(cur_r) * RSQ_W'(cur_r);
    assign hit_now   = en_q[s_q] && (dist_sq_q < DIST_W'(r_sq_q));

    // NOTE: the snapshot and pipeline registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            x_q    <= x;
            y_q    <= y;
            sx_q   <= sphere_x;
            sy_q   <= sphere_y;
            sr_q   <= sphere_r;
            scol_q <= sphere_color;
            en_q   <= sphere_en;
            bg_q   <= bg_color;
        end
        if (state_q == DIFF) begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
        if (state_q == SQR) begin
            dist_sq_q <= dist_sq_d;
            r_sq_q    <= r_sq_d;
        end
    end

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            s_q     <= '0;
            hit_q   <= 1'b0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: the pixel buffer is reset explicitly; its contents are visible at the port.
            for (int i = 0; i < JOBS_SUBDIVISION; i++) buffer_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        j_q     <= '0;
                        s_q     <= '0;
                        hit_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= DIFF;
                    end
                end
                DIFF: state_q <= SQR;
                SQR:  state_q <= CMP;
                CMP: begin
                    if (hit_now && !hit_q) begin
                        hit_q <= 1'b1;
                        col_q <= cur_col;
                    end
                    if (s_q == SW'(N_SPHERES - 1)) begin
                        state_q <= WRITE;
                    end else begin
                        s_q     <= s_q + 1'b1;
                        state_q <= DIFF;
                    end
                end
                WRITE: begin
                    buffer_q[j_q] <= hit_q ? col_q : bg_q;
                    hit_q         <= 1'b0;
                    s_q           <= '0;
                    if (j_q == JW'(JOBS_SUBDIVISION - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        j_q     <= j_q + 1'b1;
                        state_q <= DIFF;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar g = 0; g < JOBS_SUBDIVISION; g++) begin : g_buf
        assign buffer[g*COLOR_W +: COLOR_W] = buffer_q[g];
    end

endmodule

// File: doc/sphere_hit_worker.md
SPHERE_HIT_WORKER -- requirements
Module: sphere_hit_worker

Interface
REQ-001 Parameter JOBS_SUBDIVISION, 8, pixels per job; buffer depth.
REQ-002 Parameter N_WORKERS, 4, x stride between consecutive pixels of one job.
REQ-003 Parameter N_SPHERES, 4, spheres tested per pixel (>=1).
REQ-004 Parameter COORD_W, 12, signed coordinate width; RADIUS_W, 10, unsigned radius width; COLOR_W, 12, color width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 x, y  in  COORD_W each, signed  base pixel coordinate.
REQ-009 sphere_x, sphere_y  in  N_SPHERES*COORD_W, signed fields  sphere centres, index s at bits [s*COORD_W +: COORD_W].
REQ-010 sphere_r  in  N_SPHERES*RADIUS_W  radii; sphere_color  in  N_SPHERES*COLOR_W  colors; sphere_en  in  N_SPHERES  per-sphere enable.
REQ-011 bg_color  in  COLOR_W  miss color.
REQ-012 busy  out  1  job in progress; done  out  1  one-cycle completion pulse.
REQ-013 buffer  out  JOBS_SUBDIVISION*COLOR_W  pixel colors, entry j at [j*COLOR_W +: COLOR_W].

Function
REQ-014 States: IDLE, DIFF, SQR, CMP, WRITE, DONE; encoding free.
REQ-015 IDLE & start=1: latch x, y, all sphere_* inputs, sphere_en, bg_color; job j=0, sphere s=0; -> DIFF. start outside IDLE ignored.
REQ-016 local_x = x + j*N_WORKERS, computed at COORD_W+4 bits signed, no saturation.
REQ-017 DIFF: register dx = local_x - sx[s], dy = y - sy[s] (sign-extended, one bit wider than operands); -> SQR.
REQ-018 SQR: register dx*dx + dy*dy (unsigned, full width, no truncation) and r[s]*r[s] (2*RADIUS_W bits); -> CMP.
REQ-019 CMP: hit = en[s] & (dist_sq < r_sq), strictly less; on-boundary = miss; if hit and no earlier hit this pixel, hold color[s]; lowest index hit wins.
REQ-020 CMP, s<N_SPHERES-1: s+1 -> DIFF; s=N_SPHERES-1 -> WRITE.
REQ-021 WRITE: buffer[j] <= held color, or bg_color if no hit; clear hit flag; j<JOBS_SUBDIVISION-1: j+1, s=0 -> DIFF; else -> DONE.
REQ-022 DONE: done=1, busy=0 for exactly one cycle; -> IDLE.
REQ-023 busy=1 in DIFF, SQR, CMP, WRITE; 0 in IDLE, DONE.
REQ-024 Latency: start accepted at edge k -> done high in cycle k+1+JOBS_SUBDIVISION*(3*N_SPHERES+1).
REQ-025 Buffer entries change only in WRITE (entry j) or reset; previous contents held otherwise, including between jobs.
REQ-026 Input changes after start acceptance have no effect on the running job.
REQ-027 All-disabled spheres: every entry = bg_color.

Reset
REQ-028 rst=1 at any edge, any state: next cycle IDLE, busy=0, done=0, buffer all zeros, j=s=0, hit flag clear.
REQ-029 rst has priority over start; start in same cycle as rst ignored.
REQ-030 Reset mid-job aborts without done pulse; no partial-job output retained.

Verification (JOBS_SUBDIVISION=4, N_WORKERS=2, N_SPHERES=2, defaults else)
REQ-031 Reset: rst high 2 cycles -> busy=0, done=0, buffer=0 all entries.
REQ-032 Basic: x=0,y=0; s0=(3,0) r=2 color F00 en; s1 disabled; bg=000 -> buffer={000,F00,F00,000} (j0..j3), done exactly 29 cycles after start edge, single pulse.
REQ-033 Boundary/sign: x=-5,y=0; s0=(-3,0) r=2; s1 disabled -> dist_sq j0..j3 = 4,0,4,16 -> {bg,F00,bg,bg}.
REQ-034 Priority: s0 and s1 both cover all pixels, colors F00/0F0 -> all F00; s0 disabled -> all 0F0.
REQ-035 Abort: rst at cycle 10 after start -> IDLE next cycle, buffer zero, no done; new start completes normally with REQ-032 results.
REQ-036 Start while busy, and input changes mid-job: no restart, results match latched inputs, done timing unchanged.
